// File: rtl/except_pkg.sv
// Shared definitions for the exception unit: exception codes, CP0 register
// addresses and the arbiter state encoding.
package except_pkg;

    localparam logic [31:0] EXC_INT     = 32'h0000_0001;
    localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
    localparam logic [31:0] EXC_RI      = 32'h0000_000A;
    localparam logic [31:0] EXC_TRAP    = 32'h0000_000D;
    localparam logic [31:0] EXC_OV      = 32'h0000_000C;
    localparam logic [31:0] EXC_ERET    = 32'h0000_000E;

    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;

    // Cause bits software may write: IP[1:0] (9:8), IV (23) and WP (22).
    localparam logic [31:0] CAUSE_WR_MASK = 32'h00C0_0300;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_TAKE = 1'b1
    } state_t;

endpackage

// File: rtl/int_sync.sv
// Per-bit multi-stage flop synchronizer for asynchronous level inputs.
// Every stage clears on reset.
module int_sync #(
    parameter int unsigned WIDTH  = 6,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [STAGES-1:0][WIDTH-1:0] sync_q;
    logic [STAGES-1:0][WIDTH-1:0] sync_d;

    always_comb begin
        sync_d[0] = d_i;
        for (int unsigned i = 1; i < STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/except_unit.sv
// Exception arbiter and PC redirector: picks the highest-priority exception of
// the MEM-stage instruction and emits a one-cycle code/flush pulse to CP0.
module except_unit
    import except_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR  = 32'h0000_0020,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  int_i,
    input  logic        timer_int_i,
    output logic [5:0]  int_sync_o,
    input  logic        inst_valid_i,
    input  logic [4:0]  exc_flags_i,
    input  logic [31:0] inst_addr_i,
    input  logic        is_in_delayslot_i,
    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_cause_i,
    input  logic [31:0] cp0_epc_i,
    input  logic        wb_cp0_we_i,
    input  logic [4:0]  wb_cp0_waddr_i,
    input  logic [31:0] wb_cp0_data_i,
    output logic [31:0] excepttype_o,
    output logic [31:0] current_inst_addr_o,
    output logic        is_in_delayslot_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o
);

    logic [5:0] int_last;

    int_sync #(
        .WIDTH (6),
        .STAGES(SYNC_STAGES)
    ) u_int_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d_i  (int_i),
        .q_o  (int_last)
    );

    assign int_sync_o = {int_last[5] | timer_int_i, int_last[4:0]};

    logic [31:0] status_eff;
    logic [31:0] cause_eff;
    logic [31:0] epc_eff;
    logic        int_pending;
    logic [31:0] exc_code;
    logic [31:0] redirect_pc;

    always_comb begin
        status_eff = cp0_status_i;
        cause_eff  = cp0_cause_i;
        epc_eff    = cp0_epc_i;
        if (wb_cp0_we_i) begin
            if (wb_cp0_waddr_i == CP0_STATUS) status_eff = wb_cp0_data_i;
            if (wb_cp0_waddr_i == CP0_CAUSE) begin
                cause_eff = (cp0_cause_i & ~CAUSE_WR_MASK) | (wb_cp0_data_i & CAUSE_WR_MASK);
            end
            if (wb_cp0_waddr_i == CP0_EPC) epc_eff = wb_cp0_data_i;
        end

        int_pending = status_eff[0] & ~status_eff[1] &
                      (|(cause_eff[15:8] & status_eff[15:8]));

        if (int_pending)         exc_code = EXC_INT;
        else if (exc_flags_i[0]) exc_code = EXC_SYSCALL;
        else if (exc_flags_i[1]) exc_code = EXC_RI;
        else if (exc_flags_i[2]) exc_code = EXC_TRAP;
        else if (exc_flags_i[3]) exc_code = EXC_OV;
        else if (exc_flags_i[4]) exc_code = EXC_ERET;
        else                     exc_code = '0;

        redirect_pc = (exc_code == EXC_ERET) ? epc_eff : EXC_VECTOR;
    end

    logic unused_cp0_bits;
    assign unused_cp0_bits = ^{status_eff[31:16], status_eff[7:2],
                               cause_eff[31:16], cause_eff[7:0]};

    state_t      state_q, state_d;
    logic [31:0] excepttype_q, excepttype_d;
    logic [31:0] inst_addr_q, inst_addr_d;
    logic        delayslot_q, delayslot_d;
    logic        flush_q, flush_d;
    logic [31:0] new_pc_q, new_pc_d;

    always_comb begin
        state_d      = state_q;
        excepttype_d = excepttype_q;
        inst_addr_d  = inst_addr_q;
        delayslot_d  = delayslot_q;
        flush_d      = flush_q;
        new_pc_d     = new_pc_q;
        unique case (state_q)
            S_IDLE: begin
                if (inst_valid_i && (exc_code != '0)) begin
                    state_d      = S_TAKE;
                    excepttype_d = exc_code;
                    inst_addr_d  = inst_addr_i;
                    delayslot_d  = is_in_delayslot_i;
                    flush_d      = 1'b1;
                    new_pc_d     = redirect_pc;
                end
            end
            // Flags seen here belong to instructions being flushed.
            S_TAKE: begin
                state_d      = S_IDLE;
                excepttype_d = '0;
                flush_d      = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            excepttype_q <= '0;
            inst_addr_q  <= '0;
            delayslot_q  <= 1'b0;
            flush_q      <= 1'b0;
            new_pc_q     <= '0;
        end else begin
            state_q      <= state_d;
            excepttype_q <= excepttype_d;
            inst_addr_q  <= inst_addr_d;
            delayslot_q  <= delayslot_d;
            flush_q      <= flush_d;
            new_pc_q     <= new_pc_d;
        end
    end

    assign excepttype_o        = excepttype_q;
    assign current_inst_addr_o = inst_addr_q;
    assign is_in_delayslot_o   = delayslot_q;
    assign flush_o             = flush_q;
    assign new_pc_o            = new_pc_q;

endmodule

// File: tb/tb_except_unit.sv
// Scoreboard bench for except_unit: a behavioural model predicts each exception
// pulse and the synchronized interrupt lines; a negedge monitor compares.
module tb_except_unit;

    localparam logic [31:0] VEC  = 32'h0000_0020;
    localparam int          SYNC = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  int_i = '0;
    logic        timer_int_i = 1'b0;
    logic [5:0]  int_sync_o;
    logic        inst_valid_i = 1'b0;
    logic [4:0]  exc_flags_i = '0;
    logic [31:0] inst_addr_i = '0;
    logic        is_in_delayslot_i = 1'b0;
    logic [31:0] cp0_status_i = '0;
    logic [31:0] cp0_cause_i = '0;
    logic [31:0] cp0_epc_i = '0;
    logic        wb_cp0_we_i = 1'b0;
    logic [4:0]  wb_cp0_waddr_i = '0;
    logic [31:0] wb_cp0_data_i = '0;
    logic [31:0] excepttype_o;
    logic [31:0] current_inst_addr_o;
    logic        is_in_delayslot_o;
    logic        flush_o;
    logic [31:0] new_pc_o;

    except_unit #(
        .EXC_VECTOR (VEC),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .int_i              (int_i),
        .timer_int_i        (timer_int_i),
        .int_sync_o         (int_sync_o),
        .inst_valid_i       (inst_valid_i),
        .exc_flags_i        (exc_flags_i),
        .inst_addr_i        (inst_addr_i),
        .is_in_delayslot_i  (is_in_delayslot_i),
        .cp0_status_i       (cp0_status_i),
        .cp0_cause_i        (cp0_cause_i),
        .cp0_epc_i          (cp0_epc_i),
        .wb_cp0_we_i        (wb_cp0_we_i),
        .wb_cp0_waddr_i     (wb_cp0_waddr_i),
        .wb_cp0_data_i      (wb_cp0_data_i),
        .excepttype_o       (excepttype_o),
        .current_inst_addr_o(current_inst_addr_o),
        .is_in_delayslot_o  (is_in_delayslot_o),
        .flush_o            (flush_o),
        .new_pc_o           (new_pc_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [31:0] code;
        logic [31:0] addr;
        logic        ds;
        logic [31:0] pc;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         last_exp = -10;
    logic [5:0] hist [0:4095];
    logic [5:0] nx_int = '0;
    logic       nx_timer = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: architectural rules applied to the values being presented.
    function automatic logic [31:0] ref_code(output logic [31:0] pc);
        logic [31:0] st, ca, epc, code;
        logic        pend;
        logic [4:0]  order [5];
        logic [31:0] codes [5];
        st  = cp0_status_i;
        ca  = cp0_cause_i;
        epc = cp0_epc_i;
        if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd12) st = wb_cp0_data_i;
        if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd13) begin
            ca[9:8]   = wb_cp0_data_i[9:8];
            ca[22]    = wb_cp0_data_i[22];
            ca[23]    = wb_cp0_data_i[23];
        end
        if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd14) epc = wb_cp0_data_i;
        pend = (st[0] == 1'b1) && (st[1] == 1'b0) && ((ca[15:8] & st[15:8]) != 8'd0);
        order = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4};
        codes = '{32'h8, 32'hA, 32'hD, 32'hC, 32'hE};
        code = 32'h0;
        if (pend) code = 32'h1;
        else begin
            for (int k = 4; k >= 0; k--)
                if (exc_flags_i[order[k]]) code = codes[k];
        end
        pc = (code == 32'hE) ? epc : VEC;
        return code;
    endfunction

    task automatic drive(input logic valid, input logic [4:0] fl, input logic [31:0] addr,
                         input logic ds, input logic [31:0] st, input logic [31:0] ca,
                         input logic [31:0] epc, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd);
        logic [31:0] code, pc;
        @(posedge clk);
        #1;
        inst_valid_i = valid; exc_flags_i = fl; inst_addr_i = addr;
        is_in_delayslot_i = ds; cp0_status_i = st; cp0_cause_i = ca; cp0_epc_i = epc;
        wb_cp0_we_i = we; wb_cp0_waddr_i = wa; wb_cp0_data_i = wd;
        int_i = nx_int; timer_int_i = nx_timer;
        if (cyc < 4096) hist[cyc] = nx_int;
        if (valid && last_exp != cyc) begin
            code = ref_code(pc);
            if (code != 32'h0) begin
                sb.push_back('{cyc + 1, code, addr, ds, pc});
                last_exp = cyc + 1;
            end
        end
    endtask

    task automatic idle();
        drive(1'b0, 5'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && cyc >= 2 && cyc < 4096) begin
            chk("int_sync", {26'h0, int_sync_o}, {26'h0, hist[cyc-2] | {timer_int_i, 5'b0}});
            if (flush_o) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL spurious_pulse: got code %h expected no exception (cycle %0d)",
                             excepttype_o, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("pulse_cycle", cyc, e.cyc);
                    chk("excepttype", excepttype_o, e.code);
                    chk("inst_addr", current_inst_addr_o, e.addr);
                    chk("delayslot", {31'h0, is_in_delayslot_o}, {31'h0, e.ds});
                    chk("new_pc", new_pc_o, e.pc);
                end
            end else begin
                chk("idle_code", excepttype_o, 32'h0);
                if (sb.size() != 0 && sb[0].cyc <= cyc) begin
                    e = sb.pop_front();
                    checks++; errors++;
                    $display("FAIL missing_pulse: got no flush expected code %h at cycle %0d",
                             e.code, e.cyc);
                end
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_code"}, excepttype_o, 32'h0);
        chk({tag, "_flush"}, {31'h0, flush_o}, 32'h0);
        chk({tag, "_pc"}, new_pc_o, 32'h0);
        chk({tag, "_addr"}, current_inst_addr_o, 32'h0);
        chk({tag, "_ds"}, {31'h0, is_in_delayslot_o}, 32'h0);
        chk({tag, "_sync"}, {26'h0, int_sync_o}, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) hist[i] = '0;
        #2;
        chk_all_zero("reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(); idle();

        // Syscall
        drive(1'b1, 5'b00001, 32'h100, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        idle();
        chk("syscall_code", excepttype_o, 32'h8);
        chk("syscall_flush", {31'h0, flush_o}, 32'h1);
        chk("syscall_pc", new_pc_o, 32'h20);
        chk("syscall_addr", current_inst_addr_o, 32'h100);
        idle();
        chk("syscall_end_code", excepttype_o, 32'h0);
        chk("syscall_end_flush", {31'h0, flush_o}, 32'h0);

        // Interrupt beats overflow
        drive(1'b1, 5'b01000, 32'h200, 1'b1, 32'h401, 32'h400, 32'h0, 1'b0, 5'd0, 32'h0);
        idle();
        chk("int_over_ov", excepttype_o, 32'h1);
        idle();

        // Pin-to-sync latency
        nx_int = 6'b000100;
        idle();
        idle();
        chk("pin_lat1", {31'h0, int_sync_o[2]}, 32'h0);
        idle();
        chk("pin_lat2", {31'h0, int_sync_o[2]}, 32'h1);
        nx_int = '0;
        idle(); idle(); idle();

        // ERET with forwarded EPC
        drive(1'b1, 5'b10000, 32'h300, 1'b0, 32'h0, 32'h0, 32'h40, 1'b1, 5'd14, 32'h80);
        idle();
        chk("eret_code", excepttype_o, 32'hE);
        chk("eret_pc", new_pc_o, 32'h80);
        idle();

        // EXL masking, then forwarded Status clears EXL
        drive(1'b1, 5'b0, 32'h400, 1'b0, 32'h403, 32'h400, 32'h0, 1'b0, 5'd0, 32'h0);
        idle();
        chk("exl_masked", excepttype_o, 32'h0);
        drive(1'b1, 5'b0, 32'h404, 1'b0, 32'h403, 32'h400, 32'h0, 1'b1, 5'd12, 32'h401);
        idle();
        chk("exl_fwd", excepttype_o, 32'h1);
        idle();

        // Back-to-back
        drive(1'b1, 5'b00001, 32'h500, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        drive(1'b1, 5'b00010, 32'h504, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        chk("b2b_first", excepttype_o, 32'h8);
        drive(1'b1, 5'b00100, 32'h508, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        chk("b2b_gap", excepttype_o, 32'h0);
        idle();
        chk("b2b_second", excepttype_o, 32'hD);
        chk("b2b_second_addr", current_inst_addr_o, 32'h508);
        idle();

        // Reset mid-TAKE
        drive(1'b1, 5'b00001, 32'h600, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        idle();
        chk("pre_reset_flush", {31'h0, flush_o}, 32'h1);
        #5;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        last_exp = -10;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        drive(1'b1, 5'b00001, 32'h700, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        idle();
        chk("post_reset_code", excepttype_o, 32'h8);
        chk("post_reset_addr", current_inst_addr_o, 32'h700);
        idle(); idle();

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            logic [31:0] st, ca, wd;
            logic [4:0]  fl, wa;
            logic [2:0]  sel;
            st = {16'h0, 8'($urandom), 6'h0, 2'($urandom)};
            ca = $urandom;
            if ($urandom_range(0, 1) == 0) ca[15:8] = 8'h0;
            fl = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'(1 << $urandom_range(0, 5));
            sel = 3'($urandom_range(0, 3));
            wa = (sel == 3'd3) ? 5'($urandom) : 5'd12 + 5'(sel);
            wd = $urandom;
            nx_int = ($urandom_range(0, 3) == 0) ? 6'($urandom) : int_i;
            nx_timer = ($urandom_range(0, 7) == 0);
            drive($urandom_range(0, 3) != 0, fl, $urandom, 1'($urandom), st, ca, $urandom,
                  1'($urandom), wa, wd);
        end
        nx_int = '0;
        nx_timer = 1'b0;
        repeat (4) idle();
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
